// File: rtl/mux_scan_ctrl_pkg.sv
// mux_scan_pkg: shared constants, FSM state type and select helper for the mux scan controller.
package mux_scan_pkg;
    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;

    function automatic logic [SEL_W-1:0] sel_to_bits(input logic [SEL_W-1:0] n);
        return n;
    endfunction
endpackage

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: scan request, mux select/return and parallel snapshot signals.
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;
    logic           start;
    logic           y_in;
    logic           s0;
    logic           s1;
    logic [NCH-1:0] data_out;
    logic           valid;
    logic           busy;

    modport master (input start, y_in, output s0, s1, data_out, valid, busy);
    modport slave  (output start, y_in, input s0, s1, data_out, valid, busy);
endinterface

// File: rtl/mux_scan_ctrl_dwell_cnt.sv
// mux_scan_dwell_cnt: loadable down-counter with zero flag, timing the dwell per channel.
module mux_scan_dwell_cnt #(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);
    localparam int CW = $clog2(DWELL + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= CW'(DWELL - 1);
        else if (en && cnt != '0) cnt <= cnt - CW'(1);
    end

    assign zero = cnt == '0;
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux through its channels and returns a parallel snapshot.
// Define MUX_SCAN_CONTINUOUS_EN to let DONE restart a scan directly while start is held.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_scan_ctrl_if.master  bus
);
    scan_state_t    state;
    scan_state_t    nxt;
    logic [SEL_W-1:0] sel;
    logic [NCH-2:0] shadow;
    logic [NCH-1:0] data_q;
    logic           zero;
    logic           last;
    logic           restart;
    logic           load;

    assign last = sel == SEL_W'(NCH - 1);

`ifdef MUX_SCAN_CONTINUOUS_EN
    assign restart = state == DONE && bus.start;
`else
    assign restart = 1'b0;
`endif

    assign load = (state == IDLE && bus.start) || (state == SCAN && zero && !last) || restart;

    mux_scan_dwell_cnt #(.DWELL(DWELL)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .en   (state == SCAN),
        .zero (zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state == IDLE ? (bus.start ? SCAN : IDLE) :
              state == SCAN ? (zero && last ? DONE : SCAN) :
              (restart ? SCAN : IDLE);
    end

    always_comb begin
        bus.busy  = state == SCAN;
        bus.valid = state == DONE;
    end

    // The last channel bypasses the shadow so the snapshot lands on the same edge it is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel    <= '0;
            shadow <= '0;
            data_q <= '0;
        end else if (state == SCAN && zero) begin
            if (last) begin
                data_q <= {bus.y_in, shadow};
                sel    <= '0;
            end else begin
                shadow[sel] <= bus.y_in;
                sel         <= sel + SEL_W'(1);
            end
        end else if (state != SCAN) begin
            sel <= '0;
        end
    end

    assign {bus.s1, bus.s0} = sel_to_bits(sel);
    assign bus.data_out     = data_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: two controllers (DWELL=2 and DWELL=1) against a timeline model of the scan.
module tb_mux_scan_ctrl;
    import mux_scan_pkg::*;

`ifdef MUX_SCAN_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic [1:0] rst_n = 2'b00;
    logic [1:0] start = 2'b00;
    logic [3:0] mux_in [2];
    int nchk = 0;
    int nfail = 0;
    int cyc = 0;

    mux_scan_ctrl_if bus_a ();
    mux_scan_ctrl_if bus_b ();

    assign bus_a.start = start[0];
    assign bus_b.start = start[1];
    assign bus_a.y_in  = mux_in[0][{bus_a.s1, bus_a.s0}];
    assign bus_b.y_in  = mux_in[1][{bus_b.s1, bus_b.s0}];

    mux_scan_ctrl #(.DWELL(2)) dut_a (.clk(clk), .rst_n(rst_n[0]), .bus(bus_a));
    mux_scan_ctrl #(.DWELL(1)) dut_b (.clk(clk), .rst_n(rst_n[1]), .bus(bus_b));

    logic [1:0] dsel [2];
    logic       dbusy [2];
    logic       dvalid [2];
    logic [3:0] ddata [2];

    assign dsel[0]   = {bus_a.s1, bus_a.s0};
    assign dsel[1]   = {bus_b.s1, bus_b.s0};
    assign dbusy[0]  = bus_a.busy;
    assign dbusy[1]  = bus_b.busy;
    assign dvalid[0] = bus_a.valid;
    assign dvalid[1] = bus_b.valid;
    assign ddata[0]  = bus_a.data_out;
    assign ddata[1]  = bus_b.data_out;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s[%0d] cyc=%0d: got 'h%0h, expected 'h%0h", name, idx, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Model: t counts edges since the scan was accepted; -1 means idle.
    int         t [2] = '{-1, -1};
    logic [3:0] mdat [2] = '{4'h0, 4'h0};
    logic [3:0] samp [2] = '{4'h0, 4'h0};
    int         vcnt [2] = '{0, 0};
    int         vcyc [2] = '{0, 0};
    logic [3:0] vdat [2] = '{4'h0, 4'h0};
    int         vq [$];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int d;
            d = (i == 0) ? 2 : 1;
            if (!rst_n[i]) begin
                t[i] = -1;
                mdat[i] = 4'h0;
            end
            chk("sel", i, 32'(dsel[i]), (t[i] >= 0 && t[i] < 4*d) ? t[i] / d : 0);
            chk("busy", i, 32'(dbusy[i]), 32'(t[i] >= 0 && t[i] < 4*d));
            chk("valid", i, 32'(dvalid[i]), 32'(t[i] == 4*d));
            chk("data_out", i, 32'(ddata[i]), 32'(mdat[i]));
            if (dvalid[i]) begin
                vcnt[i]++;
                vcyc[i] = cyc;
                vdat[i] = ddata[i];
                if (i == 0) vq.push_back(cyc);
            end
            // Advance the model to the upcoming rising edge; inputs are already settled for it.
            if (rst_n[i]) begin
                if (t[i] < 0) begin
                    if (start[i]) t[i] = 0;
                end else begin
                    t[i]++;
                    if (t[i] % d == 0 && t[i] <= 4*d) samp[i][t[i]/d - 1] = mux_in[i][t[i]/d - 1];
                    if (t[i] == 4*d) mdat[i] = samp[i];
                    else if (t[i] == 4*d + 1) t[i] = (CONT && start[i]) ? 0 : -1;
                end
            end
        end
    end

    initial begin
        int k;
        int c0;
        logic [3:0] d0;
        mux_in[0] = 4'h0;
        mux_in[1] = 4'h0;
        tick(3);
        chk("rst_busy", 0, 32'(dbusy[0]), 0);
        chk("rst_valid", 1, 32'(dvalid[1]), 0);
        chk("rst_data", 0, 32'(ddata[0]), 0);
        rst_n = 2'b11;
        tick(10);
        chk("idle_sel", 0, 32'(dsel[0]), 0);
        chk("idle_busy", 1, 32'(dbusy[1]), 0);

        mux_in[0] = 4'b1101;
        k = cyc + 1;
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        tick(12);
        chk("basic_valid_cyc", 0, vcyc[0], k + 8);
        chk("basic_data", 0, 32'(vdat[0]), 32'b1101);
        chk("basic_count", 0, vcnt[0], 1);

        mux_in[1] = 4'b0010;
        c0 = vcnt[1];
        k = cyc + 1;
        start[1] = 1'b1;
        tick(1);
        start[1] = 1'b0;
        tick(1);
        start[1] = 1'b1;
        tick(2);
        start[1] = 1'b0;
        tick(6);
        chk("d1_count", 1, vcnt[1], c0 + 1);
        chk("d1_valid_cyc", 1, vcyc[1], k + 4);
        chk("d1_data", 1, 32'(vdat[1]), 32'b0010);

        mux_in[0] = 4'b0110;
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        tick(4);
        rst_n[0] = 1'b0;
        #1;
        chk("midrst_busy", 0, 32'(dbusy[0]), 0);
        chk("midrst_data", 0, 32'(ddata[0]), 0);
        chk("midrst_sel", 0, 32'(dsel[0]), 0);
        tick(1);
        rst_n[0] = 1'b1;
        c0 = vcnt[0];
        tick(10);
        chk("midrst_no_valid", 0, vcnt[0], c0);
        mux_in[0] = 4'b1010;
        k = cyc + 1;
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        tick(12);
        chk("rescan_valid_cyc", 0, vcyc[0], k + 8);
        chk("rescan_data", 0, 32'(vdat[0]), 32'b1010);

        vq.delete();
        k = cyc + 1;
        start[0] = 1'b1;
        tick(30);
        start[0] = 1'b0;
        tick(12);
        chk("hold_count_ge3", 0, 32'(vq.size() >= 3), 1);
        if (vq.size() >= 3) begin
            chk("hold_valid0", 0, vq[0], k + 8);
            chk("hold_valid1", 0, vq[1], k + (CONT ? 17 : 18));
            chk("hold_valid2", 0, vq[2], k + (CONT ? 26 : 28));
        end

        d0 = ddata[0];
        c0 = vcnt[0];
        mux_in[0] = ~mux_in[0];
        mux_in[1] = ~mux_in[1];
        tick(10);
        chk("stable_data", 0, 32'(ddata[0]), 32'(d0));
        chk("stable_data", 1, 32'(ddata[1]), 32'b0010);
        chk("stable_no_valid", 0, vcnt[0], c0);

        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $finish;
    end
endmodule
